// File: rtl/lcd_ctrl_if.sv
// Byte-write handshake between a requester (such as the LSU-side LCD register) and lcd_ctrl.
// The requester holds rs/data stable while vld is high. The controller samples them only on the accept edge.
interface lcd_ctrl_if;
  logic       i_wr_vld;
  logic       i_wr_rs;
  logic [7:0] i_wr_data;
  logic       o_wr_rdy;

  modport master (output i_wr_vld, output i_wr_rs, output i_wr_data, input o_wr_rdy);
  modport slave  (input i_wr_vld, input i_wr_rs, input i_wr_data, output o_wr_rdy);
endinterface

// File: rtl/lcd_ctrl.sv
// Write-only HD44780 character LCD controller: it runs power-on init by itself and then
// sequences every byte through setup, EN pulse, hold and busy wait.
module lcd_ctrl #(
  parameter int unsigned T_PWRON = 2000000,
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_HOLD  = 4,
  parameter int unsigned T_CMD   = 2500,
  parameter int unsigned T_LONG  = 82000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  lcd_ctrl_if.slave  wr,
  output logic       o_init_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

  typedef enum logic [2:0] {PWR_WAIT, SETUP, EN_HI, HOLD, WAIT, IDLE} state_t;

  localparam logic [31:0] PWRON_LAST = 32'(T_PWRON - 1);
  localparam logic [31:0] SETUP_LAST = 32'(T_SETUP - 1);
  localparam logic [31:0] EN_LAST    = 32'(T_EN - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(T_HOLD - 1);
  localparam logic [31:0] CMD_LAST   = 32'(T_CMD - 1);
  localparam logic [31:0] LONG_LAST  = 32'(T_LONG - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        en_q, en_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic        on_q;
  logic [31:0] waitLast;

  function automatic logic [7:0] initByte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: initByte = 8'h38;
      3'd3:             initByte = 8'h0C;
      3'd4:             initByte = 8'h01;
      default:          initByte = 8'h06;
    endcase
  endfunction

  // Clear and home need the long busy wait. Only the latched command byte decides this.
  assign waitLast = (!rs_q && (data_q == 8'h01 || data_q == 8'h02)) ? LONG_LAST : CMD_LAST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    idx_d   = idx_q;
    data_d  = data_q;
    rs_d    = rs_q;
    done_d  = done_q;
    case (state_q)
      PWR_WAIT: if (cnt_q == PWRON_LAST) begin
        state_d = SETUP;
        idx_d   = 3'd0;
        data_d  = initByte(3'd0);
        rs_d    = 1'b0;
      end
      SETUP: if (cnt_q == SETUP_LAST) state_d = EN_HI;
      EN_HI: if (cnt_q == EN_LAST)    state_d = HOLD;
      HOLD:  if (cnt_q == HOLD_LAST)  state_d = WAIT;
      WAIT: if (cnt_q == waitLast) begin
        if (!done_q && idx_q < 3'd5) begin
          state_d = SETUP;
          idx_d   = idx_q + 3'd1;
          data_d  = initByte(idx_q + 3'd1);
          rs_d    = 1'b0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      IDLE: begin
        cnt_d = cnt_q;
        if (wr.i_wr_vld && rdy_q) begin
          state_d = SETUP;
          data_d  = wr.i_wr_data;
          rs_d    = wr.i_wr_rs;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
    if (state_d != state_q) cnt_d = 32'd0;
    en_d  = (state_d == EN_HI);
    rdy_d = (state_d == IDLE) && done_d;
  end

  // The pin-facing outputs come from next-state values, so every output is a plain flop.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= PWR_WAIT;
      cnt_q   <= 32'd0;
      idx_q   <= 3'd0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      on_q    <= 1'b1;
    end
  end

  assign wr.o_wr_rdy = rdy_q;
  assign o_init_done = done_q;
  assign o_lcd_data  = data_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = en_q;
  assign o_lcd_on    = on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed testbench for lcd_ctrl with shortened timing. Each scenario task checks its own results.
// A negedge monitor records every EN pulse so that latch values and widths can be compared afterwards.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       initDone;
  logic [7:0] lcdData;
  logic       lcdRs, lcdRw, lcdEn, lcdOn;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;

  logic [7:0] pulseData[$];
  logic       pulseRs[$];
  int         pulseEdge[$];
  int         pulseLen[$];
  int         enLen = 0;
  logic       enPrev = 1'b0;
  logic [7:0] dataPrev = 8'h00;
  int         dataGlitch = 0;
  logic       rwBad = 1'b0;

  lcd_ctrl_if wrIf ();

  lcd_ctrl #(
    .T_PWRON(20), .T_SETUP(2), .T_EN(3), .T_HOLD(1), .T_CMD(4), .T_LONG(12)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .wr          (wrIf),
    .o_init_done (initDone),
    .o_lcd_data  (lcdData),
    .o_lcd_rs    (lcdRs),
    .o_lcd_rw    (lcdRw),
    .o_lcd_en    (lcdEn),
    .o_lcd_on    (lcdOn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Records each EN pulse: the latched byte at the rise, and the width at the fall.
  always @(negedge clk) begin
    if (lcdEn === 1'b1 && enPrev !== 1'b1) begin
      pulseData.push_back(lcdData);
      pulseRs.push_back(lcdRs);
      pulseEdge.push_back(cyc);
    end
    if (lcdEn === 1'b1) enLen++;
    if (lcdEn !== 1'b1 && enPrev === 1'b1) begin
      pulseLen.push_back(enLen);
      enLen = 0;
    end
    if (lcdEn === 1'b1 && enPrev === 1'b1 && lcdData !== dataPrev) dataGlitch++;
    if (lcdRw !== 1'b0) rwBad = 1'b1;
    enPrev   = lcdEn;
    dataPrev = lcdData;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearPulses();
    pulseData.delete();
    pulseRs.delete();
    pulseEdge.delete();
    pulseLen.delete();
  endtask

  // Holds reset, releases it, and runs to edge 88 after release while noting early behaviour.
  task automatic runInit(input logic early, output logic onAt1, output logic rdyEarly,
                         output logic data55Early, output int base);
    reset = 1'b1;
    step();
    step();
    wrIf.i_wr_vld  = early;
    wrIf.i_wr_rs   = 1'b1;
    wrIf.i_wr_data = 8'h55;
    clearPulses();
    reset = 1'b0;
    base = cyc;
    onAt1 = 1'b0;
    rdyEarly = 1'b0;
    data55Early = 1'b0;
    for (int e = 1; e <= 88; e++) begin
      step();
      if (e == 1) onAt1 = lcdOn;
      if (e < 88 && wrIf.o_wr_rdy !== 1'b0) rdyEarly = 1'b1;
      if (e < 88 && lcdData === 8'h55) data55Early = 1'b1;
    end
  endtask

  task automatic waitRdy(output int busy);
    busy = 0;
    while (wrIf.o_wr_rdy !== 1'b1 && busy < 200) begin
      step();
      busy++;
    end
  endtask

  task automatic writeByte(input logic rs, input logic [7:0] d, output int busy);
    wrIf.i_wr_vld  = 1'b1;
    wrIf.i_wr_rs   = rs;
    wrIf.i_wr_data = d;
    step();
    wrIf.i_wr_vld = 1'b0;
    waitRdy(busy);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wrIf.i_wr_vld  = 1'b0;
    wrIf.i_wr_rs   = 1'b0;
    wrIf.i_wr_data = 8'h00;
    step();
    step();
    checks++; if (lcdOn !== 1'b0) begin failures++; $display("[TB] FAIL reset_on got=%b exp=0", lcdOn); end
    checks++; if (lcdEn !== 1'b0) begin failures++; $display("[TB] FAIL reset_en got=%b exp=0", lcdEn); end
    checks++; if (lcdData !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", lcdData); end
    checks++; if (lcdRs !== 1'b0) begin failures++; $display("[TB] FAIL reset_rs got=%b exp=0", lcdRs); end
    checks++; if (lcdRw !== 1'b0) begin failures++; $display("[TB] FAIL reset_rw got=%b exp=0", lcdRw); end
    checks++; if (wrIf.o_wr_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_rdy got=%b exp=0", wrIf.o_wr_rdy); end
    checks++; if (initDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", initDone); end
  endtask

  task automatic test_power_on();
    logic       onAt1, rdyEarly, data55Early;
    int         base;
    logic [7:0] expData[6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int         expRise[6] = '{22, 32, 42, 52, 62, 80};
    runInit(1'b0, onAt1, rdyEarly, data55Early, base);
    checks++; if (onAt1 !== 1'b1) begin failures++; $display("[TB] FAIL pwr_on_edge1 got=%b exp=1", onAt1); end
    checks++; if (rdyEarly !== 1'b0) begin failures++; $display("[TB] FAIL pwr_rdy_early got=%b exp=0", rdyEarly); end
    checks++; if (initDone !== 1'b1) begin failures++; $display("[TB] FAIL pwr_done_88 got=%b exp=1", initDone); end
    checks++; if (wrIf.o_wr_rdy !== 1'b1) begin failures++; $display("[TB] FAIL pwr_rdy_88 got=%b exp=1", wrIf.o_wr_rdy); end
    checks++; if (pulseData.size() != 6) begin failures++; $display("[TB] FAIL pwr_pulse_count got=%0d exp=6", pulseData.size()); end
    for (int i = 0; i < 6 && i < pulseData.size(); i++) begin
      checks++; if (pulseData[i] !== expData[i]) begin failures++; $display("[TB] FAIL pwr_byte%0d got=%h exp=%h", i, pulseData[i], expData[i]); end
      checks++; if (pulseRs[i] !== 1'b0) begin failures++; $display("[TB] FAIL pwr_rs%0d got=%b exp=0", i, pulseRs[i]); end
      checks++; if (pulseEdge[i] - base != expRise[i]) begin failures++; $display("[TB] FAIL pwr_rise%0d got=%0d exp=%0d", i, pulseEdge[i] - base, expRise[i]); end
      if (i < pulseLen.size()) begin
        checks++; if (pulseLen[i] != 3) begin failures++; $display("[TB] FAIL pwr_width%0d got=%0d exp=3", i, pulseLen[i]); end
      end
    end
  endtask

  task automatic test_data_write();
    logic expEn;
    wrIf.i_wr_vld  = 1'b1;
    wrIf.i_wr_rs   = 1'b1;
    wrIf.i_wr_data = 8'h41;
    step();
    wrIf.i_wr_vld = 1'b0;
    checks++; if (lcdData !== 8'h41) begin failures++; $display("[TB] FAIL dw_data got=%h exp=41", lcdData); end
    checks++; if (lcdRs !== 1'b1) begin failures++; $display("[TB] FAIL dw_rs got=%b exp=1", lcdRs); end
    checks++; if (wrIf.o_wr_rdy !== 1'b0) begin failures++; $display("[TB] FAIL dw_rdy_accept got=%b exp=0", wrIf.o_wr_rdy); end
    for (int k = 1; k <= 10; k++) begin
      step();
      expEn = (k >= 2 && k <= 4);
      checks++; if (lcdEn !== expEn) begin failures++; $display("[TB] FAIL dw_en_edge%0d got=%b exp=%b", k, lcdEn, expEn); end
      checks++; if (wrIf.o_wr_rdy !== (k == 10)) begin failures++; $display("[TB] FAIL dw_rdy_edge%0d got=%b exp=%b", k, wrIf.o_wr_rdy, (k == 10)); end
    end
  endtask

  task automatic test_clear();
    int busy;
    writeByte(1'b0, 8'h01, busy);
    checks++; if (busy != 18) begin failures++; $display("[TB] FAIL clr_busy got=%0d exp=18", busy); end
    writeByte(1'b1, 8'h01, busy);
    checks++; if (busy != 10) begin failures++; $display("[TB] FAIL data01_busy got=%0d exp=10", busy); end
    writeByte(1'b0, 8'h02, busy);
    checks++; if (busy != 18) begin failures++; $display("[TB] FAIL home_busy got=%0d exp=18", busy); end
    writeByte(1'b0, 8'h03, busy);
    checks++; if (busy != 10) begin failures++; $display("[TB] FAIL cmd03_busy got=%0d exp=10", busy); end
  endtask

  task automatic test_back_to_back();
    int busy;
    clearPulses();
    dataGlitch = 0;
    wrIf.i_wr_vld  = 1'b1;
    wrIf.i_wr_rs   = 1'b1;
    wrIf.i_wr_data = 8'h48;
    step();
    checks++; if (lcdData !== 8'h48) begin failures++; $display("[TB] FAIL b2b_first_data got=%h exp=48", lcdData); end
    wrIf.i_wr_data = 8'h49;
    waitRdy(busy);
    checks++; if (busy != 10) begin failures++; $display("[TB] FAIL b2b_first_busy got=%0d exp=10", busy); end
    checks++; if (lcdData !== 8'h48) begin failures++; $display("[TB] FAIL b2b_ignored_while_busy got=%h exp=48", lcdData); end
    step();
    wrIf.i_wr_vld = 1'b0;
    checks++; if (lcdData !== 8'h49) begin failures++; $display("[TB] FAIL b2b_second_data got=%h exp=49", lcdData); end
    checks++; if (wrIf.o_wr_rdy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_second_rdy got=%b exp=0", wrIf.o_wr_rdy); end
    waitRdy(busy);
    checks++; if (busy != 10) begin failures++; $display("[TB] FAIL b2b_second_busy got=%0d exp=10", busy); end
    checks++; if (pulseData.size() != 2) begin failures++; $display("[TB] FAIL b2b_pulse_count got=%0d exp=2", pulseData.size()); end
    if (pulseData.size() == 2) begin
      checks++; if (pulseData[0] !== 8'h48) begin failures++; $display("[TB] FAIL b2b_pulse0 got=%h exp=48", pulseData[0]); end
      checks++; if (pulseData[1] !== 8'h49) begin failures++; $display("[TB] FAIL b2b_pulse1 got=%h exp=49", pulseData[1]); end
    end
    checks++; if (dataGlitch != 0) begin failures++; $display("[TB] FAIL b2b_data_during_en got=%0d exp=0", dataGlitch); end
  endtask

  task automatic test_early_request();
    logic onAt1, rdyEarly, data55Early;
    int   base, busy;
    runInit(1'b1, onAt1, rdyEarly, data55Early, base);
    checks++; if (rdyEarly !== 1'b0) begin failures++; $display("[TB] FAIL early_rdy got=%b exp=0", rdyEarly); end
    checks++; if (data55Early !== 1'b0) begin failures++; $display("[TB] FAIL early_data55 got=%b exp=0", data55Early); end
    checks++; if (wrIf.o_wr_rdy !== 1'b1) begin failures++; $display("[TB] FAIL early_rdy_88 got=%b exp=1", wrIf.o_wr_rdy); end
    checks++; if (lcdData !== 8'h06) begin failures++; $display("[TB] FAIL early_data_88 got=%h exp=06", lcdData); end
    step();
    wrIf.i_wr_vld = 1'b0;
    checks++; if (lcdData !== 8'h55) begin failures++; $display("[TB] FAIL early_accept_data got=%h exp=55", lcdData); end
    checks++; if (lcdRs !== 1'b1) begin failures++; $display("[TB] FAIL early_accept_rs got=%b exp=1", lcdRs); end
    checks++; if (wrIf.o_wr_rdy !== 1'b0) begin failures++; $display("[TB] FAIL early_accept_rdy got=%b exp=0", wrIf.o_wr_rdy); end
    waitRdy(busy);
    checks++; if (busy != 10) begin failures++; $display("[TB] FAIL early_busy got=%0d exp=10", busy); end
  endtask

  task automatic test_reset_mid();
    wrIf.i_wr_vld  = 1'b1;
    wrIf.i_wr_rs   = 1'b1;
    wrIf.i_wr_data = 8'h5A;
    step();
    wrIf.i_wr_vld = 1'b0;
    step();
    step();
    checks++; if (lcdEn !== 1'b1) begin failures++; $display("[TB] FAIL mid_in_en_hi got=%b exp=1", lcdEn); end
    reset = 1'b1;
    step();
    checks++; if (lcdEn !== 1'b0) begin failures++; $display("[TB] FAIL mid_en got=%b exp=0", lcdEn); end
    checks++; if (lcdData !== 8'h00) begin failures++; $display("[TB] FAIL mid_data got=%h exp=00", lcdData); end
    checks++; if (lcdRs !== 1'b0) begin failures++; $display("[TB] FAIL mid_rs got=%b exp=0", lcdRs); end
    checks++; if (initDone !== 1'b0) begin failures++; $display("[TB] FAIL mid_done got=%b exp=0", initDone); end
    checks++; if (lcdOn !== 1'b0) begin failures++; $display("[TB] FAIL mid_on got=%b exp=0", lcdOn); end
    checks++; if (wrIf.o_wr_rdy !== 1'b0) begin failures++; $display("[TB] FAIL mid_rdy got=%b exp=0", wrIf.o_wr_rdy); end
    test_power_on();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_power_on();
    test_data_write();
    test_clear();
    test_back_to_back();
    test_early_request();
    test_reset_mid();
    checks++; if (rwBad !== 1'b0) begin failures++; $display("[TB] FAIL rw_always_low got=%b exp=0", rwBad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
